// File: rtl/ps_serializer_pkg.sv
// Shared types, default parameters and helpers for the ps_serializer
// transmitter and the receive block that reuses ps_bit_timer.
package ps_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ps_state_e;

  localparam int unsigned DEF_WIDTH        = 10;
  localparam int unsigned DEF_CLKS_PER_BIT = 1;
  localparam int unsigned DEF_MSB_FIRST    = 1;
  localparam logic        DEF_IDLE_LEVEL   = 1'b1;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ps_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each period on periodEnd.
module ps_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic periodEnd
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count;

  assign periodEnd = enable && (count == CW'(CLKS_PER_BIT - 1));

  // Period counter; clear has priority so a new frame starts a fresh period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || periodEnd) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ps_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load handshake,
// programmable bit period and gap-free back-to-back frames.
// Optional even-parity bit: define PS_SERIALIZER_PARITY_EN.
module ps_serializer
  import ps_serializer_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned MSB_FIRST    = DEF_MSB_FIRST,
  parameter logic        IDLE_LEVEL   = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             loadValid,
  output logic             loadReady,
  output logic             serialOut,
  output logic             busy,
  output logic             frameDone
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  ps_state_e        state_q, state_d;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shift;
  logic [BCW-1:0]   bit_cnt;
  logic             serial_q;
  logic [1:0]       armed;
  logic             period_end;
  logic             step;
  logic             frame_last;
  logic             load_ready;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
`ifdef PS_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  ps_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (state_q != IDLE),
    .periodEnd(period_end)
  );

  assign sreg_shift = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign next_bit   = (MSB_FIRST != 0) ? sreg_shift[WIDTH-1] : sreg_shift[0];
  assign first_bit  = (MSB_FIRST != 0) ? parallelIn[WIDTH-1] : parallelIn[0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and frame-end decode; an accepted load overrides
  // the return to IDLE so back-to-back frames stay in SHIFT.
  always_comb begin
    state_d    = state_q;
    step       = 1'b0;
    frame_last = 1'b0;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (period_end) begin
          step = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef PS_SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            frame_last = 1'b1;
            state_d    = IDLE;
`endif
          end
        end
      end
`ifdef PS_SERIALIZER_PARITY_EN
      PARITY: begin
        if (period_end) begin
          frame_last = 1'b1;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    load_ready = armed[1] && ((state_q == IDLE) || frame_last);
    accept     = loadValid && load_ready;
    if (accept) begin
      state_d = SHIFT;
    end
  end

  // Two-stage arm so loadReady stays low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= '0;
    end else begin
      armed <= {armed[0], 1'b1};
    end
  end

  // Shift register, bit counter and registered serial output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      serial_q <= IDLE_LEVEL;
`ifdef PS_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else if (accept) begin
      sreg     <= parallelIn;
      bit_cnt  <= '0;
      serial_q <= first_bit;
`ifdef PS_SERIALIZER_PARITY_EN
      par_q    <= even_parity(PAR_MAX_W'(parallelIn));
`endif
    end else if (step) begin
      sreg    <= sreg_shift;
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_cnt == LAST_BIT) begin
`ifdef PS_SERIALIZER_PARITY_EN
        serial_q <= par_q;
`else
        serial_q <= IDLE_LEVEL;
`endif
      end else begin
        serial_q <= next_bit;
      end
    end else if (frame_last) begin
      serial_q <= IDLE_LEVEL;
    end
  end

  assign loadReady = load_ready;
  assign serialOut = serial_q;
  assign busy      = (state_q != IDLE);
  assign frameDone = frame_last;

endmodule

// File: tb/tb_ps_serializer.sv
// Directed bench for ps_serializer: instance A (10 bits, 1 clk/bit, MSB first)
// and instance B (10 bits, 3 clks/bit, LSB first).
module tb_ps_serializer;

`ifdef PS_SERIALIZER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  // Transmit order, first bit at [10], parity bit at [0] (used only with parity).
  localparam logic [10:0] SEQ_A1 = {10'b1110010100, 1'b1};
  localparam logic [10:0] SEQ_A2 = {10'b1001011100, 1'b1};
  localparam logic [10:0] SEQ_B  = {10'b0011101001, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] pin_a = '0, pin_b = '0;
  logic       lv_a = 1'b0, lv_b = 1'b0;
  logic       rdy_a, so_a, busy_a, fd_a;
  logic       rdy_b, so_b, busy_b, fd_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps_serializer #(.WIDTH(10), .CLKS_PER_BIT(1), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .parallelIn(pin_a), .loadValid(lv_a),
    .loadReady(rdy_a), .serialOut(so_a), .busy(busy_a), .frameDone(fd_a)
  );

  ps_serializer #(.WIDTH(10), .CLKS_PER_BIT(3), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .parallelIn(pin_b), .loadValid(lv_b),
    .loadReady(rdy_b), .serialOut(so_b), .busy(busy_b), .frameDone(fd_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame on instance sel; a rejected zero word is offered over cycles [jlo, jhi).
  task automatic frame(input bit sel, input logic [9:0] word, input logic [10:0] seq,
                       input int cpb, input int jlo, input int jhi);
    int len;
    len = NB * cpb;
    if (sel) begin lv_b = 1'b1; pin_b = word; end
    else     begin lv_a = 1'b1; pin_a = word; end
    @(posedge clk); @(negedge clk);
    lv_a = 1'b0; lv_b = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (c == jlo) begin
        if (sel) begin lv_b = 1'b1; pin_b = '0; end
        else     begin lv_a = 1'b1; pin_a = '0; end
      end
      if (c == jhi) begin lv_a = 1'b0; lv_b = 1'b0; end
      check("serial", sel ? so_b : so_a, seq[10 - (c - 1) / cpb]);
      check("busy",   sel ? busy_b : busy_a, 1'b1);
      check("done",   sel ? fd_b : fd_a, c == len);
      check("ready",  sel ? rdy_b : rdy_a, c == len);
      @(negedge clk);
    end
    check("idle_serial", sel ? so_b : so_a, 1'b1);
    check("idle_busy",   sel ? busy_b : busy_a, 1'b0);
    check("idle_done",   sel ? fd_b : fd_a, 1'b0);
    check("idle_ready",  sel ? rdy_b : rdy_a, 1'b1);
  endtask

  // Two words back to back on instance A with loadValid held high.
  task automatic b2b();
    lv_a = 1'b1; pin_a = 10'b1110010100;
    @(posedge clk); @(negedge clk);
    pin_a = 10'b1001011100;
    for (int c = 1; c <= 2 * NB; c++) begin
      if (c == NB + 1) lv_a = 1'b0;
      check("b2b_serial", so_a, (c <= NB) ? SEQ_A1[10 - (c - 1)] : SEQ_A2[10 - (c - NB - 1)]);
      check("b2b_busy", busy_a, 1'b1);
      check("b2b_done", fd_a, (c == NB) || (c == 2 * NB));
      check("b2b_ready", rdy_a, (c == NB) || (c == 2 * NB));
      @(negedge clk);
    end
    check("b2b_idle_serial", so_a, 1'b1);
    check("b2b_idle_busy", busy_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_serial", so_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", fd_a, 1'b0);
    check("rst_ready", rdy_a, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready0", rdy_a, 1'b0);
    @(negedge clk);
    check("post_rst_ready1", rdy_a, 1'b1);
    check("post_rst_ready1_b", rdy_b, 1'b1);

    frame(1'b0, 10'b1110010100, SEQ_A1, 1, 0, 0);
    frame(1'b1, 10'b1001011100, SEQ_B, 3, 0, 0);
    b2b();
    frame(1'b0, 10'b1110010100, SEQ_A1, 1, 3, 7);
    @(negedge clk);

    // Reset during cycle 4 of a frame.
    lv_a = 1'b1; pin_a = 10'b1110010100;
    @(posedge clk); @(negedge clk);
    lv_a = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_serial", so_a, SEQ_A1[7]);
    check("mid_busy", busy_a, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_serial", so_a, 1'b1);
    check("arst_busy", busy_a, 1'b0);
    check("arst_done", fd_a, 1'b0);
    check("arst_ready", rdy_a, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready0", rdy_a, 1'b0);
    check("rel_serial", so_a, 1'b1);
    @(negedge clk);
    check("rel_ready1", rdy_a, 1'b1);
    frame(1'b0, 10'b1001011100, SEQ_A2, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
